riscv_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the instruction decoder.

---
 rtl/riscv_constants.sv | 7 +
 rtl/riscv_defs.sv | 22 ++
 rtl/riscv_fetch_fifo.sv | 50 +++++
 rtl/riscv_fetch.sv | 133 +++++++++++++
 tb/tb_riscv_fetch.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_constants.sv
// Architectural constants shared by the fetch stage and its bench.
package riscv_constants;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/riscv_defs.sv
// Shared fetch-stage types: FSM state encoding, FIFO entry layout, saturating add.
package riscv_defs;

  localparam int XLEN = 32;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } FETCH_STATE;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; DEPTH must be a power of 2.
module riscv_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: PC, credit-limited imem issue, in-order {pc,inst} buffer, redirect flush.
// Optional perf counters enabled by defining RISCV_FETCH_PERF_EN.
module riscv_fetch
  import riscv_defs::*;
  import riscv_constants::*;
#(
  parameter int                WORD_LENGTH = 32,
  parameter logic [31:0]       RESET_PC    = RESET_PC_DEF,
  parameter int                DEPTH       = 4,
  parameter int                MAX_OUTST   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  input  logic                   imem_gnt_i,
  output logic [WORD_LENGTH-1:0] imem_addr_o,
  input  logic                   imem_rvalid_i,
  input  logic [WORD_LENGTH-1:0] imem_rdata_i,
  input  logic                   redirect_i,
  input  logic [WORD_LENGTH-1:0] redirect_pc_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [WORD_LENGTH-1:0] inst_o,
`ifdef RISCV_FETCH_PERF_EN
  output logic [WORD_LENGTH-1:0] pc_o,
  output logic [31:0]            perf_fetched_o,
  output logic [31:0]            perf_flushed_o
`else
  output logic [WORD_LENGTH-1:0] pc_o
`endif
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);
  localparam logic [CW:0]   MAXO_C  = (CW+1)'(MAX_OUTST);

  FETCH_STATE             state_q;
  logic [WORD_LENGTH-1:0] pc_q;
  logic [CW:0]            outst_q, drop_q, outst_nx;
  logic [CW:0]            inst_cnt, tag_cnt;
  logic [CW+1:0]          credit;
  logic                   grant, rsp_keep, pop;
  logic [WORD_LENGTH-1:0] tag_pc;
  fetch_entry_t           push_ent, head_ent;

  assign credit     = {1'b0, inst_cnt} + {1'b0, outst_q};
  assign imem_req_o = !rst && state_q == FETCH_RUN && !redirect_i &&
                      credit < DEPTH_C && outst_q < MAXO_C;
  assign imem_addr_o = pc_q;
  assign grant      = imem_req_o & imem_gnt_i;
  // Responses are only buffered in RUN; the redirect cycle's response is stale by definition.
  assign rsp_keep   = imem_rvalid_i && state_q == FETCH_RUN && !redirect_i && tag_cnt != '0;

  assign inst_valid_o = inst_cnt != '0 && !redirect_i;
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = head_ent.inst;
  assign pc_o         = head_ent.pc;
  assign push_ent     = '{pc: tag_pc, inst: imem_rdata_i};

  always_comb begin
    outst_nx = outst_q;
    if (grant)         outst_nx = outst_nx + (CW+1)'(1);
    if (imem_rvalid_i) outst_nx = outst_nx - (CW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_nx;
      if (redirect_i) begin
        // Everything still in flight after this edge is stale.
        pc_q    <= redirect_pc_i & ~(WORD_LENGTH'(3));
        drop_q  <= outst_nx;
        state_q <= (outst_nx != '0) ? FETCH_FLUSH : FETCH_RUN;
      end else begin
        if (grant) pc_q <= pc_q + WORD_LENGTH'(4);
        if (state_q == FETCH_FLUSH && imem_rvalid_i) begin
          drop_q <= drop_q - (CW+1)'(1);
          if (drop_q == (CW+1)'(1)) state_q <= FETCH_RUN;
        end
      end
    end
  end

  riscv_fetch_fifo #(.WIDTH(WORD_LENGTH), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .pop_i   (rsp_keep),
    .flush_i (redirect_i),
    .data_i  (pc_q),
    .data_o  (tag_pc),
    .count_o (tag_cnt)
  );

  riscv_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_ent),
    .data_o  (head_ent),
    .count_o (inst_cnt)
  );

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] flush_inc;

  always_comb begin
    flush_inc = '0;
    if (redirect_i)
      flush_inc = 32'(inst_cnt) + 32'(imem_rvalid_i);
    else if (state_q == FETCH_FLUSH && imem_rvalid_i)
      flush_inc = 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_o <= '0;
      perf_flushed_o <= '0;
    end else begin
      perf_fetched_o <= sat_add32(perf_fetched_o, 32'(pop));
      perf_flushed_o <= sat_add32(perf_flushed_o, flush_inc);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: imem responder model, {pc,inst} scoreboard, vector table and corner sequences.
module tb_riscv_fetch;
  import riscv_constants::*;

  localparam logic [31:0] RST1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        gnt = 1'b0, rvalid = 1'b0, redir = 1'b0, ready = 1'b0;
  logic [31:0] rdata = 32'h0, redir_pc = 32'h0;
  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, inst0, pc0, addr1, inst1, pc1;
`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] pf0, pl0, pf1, pl1;
`endif

  always #5 clk = ~clk;

  riscv_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req_o(req0), .imem_gnt_i(gnt), .imem_addr_o(addr0),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redir), .redirect_pc_i(redir_pc),
    .inst_valid_o(valid0), .inst_ready_i(ready), .inst_o(inst0), .pc_o(pc0)
`ifdef RISCV_FETCH_PERF_EN
    , .perf_fetched_o(pf0), .perf_flushed_o(pl0)
`endif
  );

  riscv_fetch #(.RESET_PC(RST1)) dut1 (
    .clk(clk), .rst(rst), .imem_req_o(req1), .imem_gnt_i(gnt), .imem_addr_o(addr1),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redir), .redirect_pc_i(redir_pc),
    .inst_valid_o(valid1), .inst_ready_i(ready), .inst_o(inst1), .pc_o(pc1)
`ifdef RISCV_FETCH_PERF_EN
    , .perf_fetched_o(pf1), .perf_flushed_o(pl1)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic gnt; logic rdy; logic exp_req; logic [31:0] exp_addr;
                   logic exp_valid; logic [31:0] exp_pc; } vec_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc_n = 0, epoch = 0, lat = 1;
  int          gnt_budget = 0, delivered = 0;
  logic        rsp_en = 1'b1, ready_en = 1'b0, prev_pend = 1'b0, first_pend = 1'b0;
  logic [31:0] exp_fetch_pc = 32'h0, prev_addr = 32'h0, first_tgt = 32'h0;
  vec_t        tv[6];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5EED_1234) + 32'h0000_0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic step();
    mreq_t m;
    exp_t  e;
    logic  stale, hs_req;
    gnt   = (gnt_budget != 0);
    ready = ready_en;
    if (rsp_en && mq.size() > 0 && mq[0].due <= cyc_n) begin
      rvalid = 1'b1; rdata = memf(mq[0].addr);
    end else begin
      rvalid = 1'b0; rdata = INST_NOP;
    end
    #1;
    hs_req = req0 & gnt;
    stale = 1'b0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale = 1'b1;
    if (stale) chk("no_req_in_flush", 32'(req0), 0);
    if (prev_pend && !redir) begin
      chk("req_held", 32'(req0), 1);
      chk("addr_held", addr0, prev_addr);
    end
    if (redir) begin
      chk("redir_req_low", 32'(req0), 0);
      chk("redir_valid_low", 32'(valid0), 0);
    end
    if (valid0 && ready) begin
      delivered++;
      if (sb.size() == 0) chk("spurious_inst", 32'(valid0), 0);
      else begin
        e = sb.pop_front();
        chk("pc_o", pc0, e.pc);
        chk("inst_o", inst0, e.inst);
      end
      if (first_pend) begin
        chk("first_pc_after_redirect", pc0, first_tgt);
        first_pend = 1'b0;
      end
    end
    if (rvalid) begin
      m = mq.pop_front();
      if (!redir && m.epoch == epoch) sb.push_back({m.addr, memf(m.addr)});
    end
    if (redir) begin
      sb.delete();
      epoch++;
      exp_fetch_pc = redir_pc & ~32'h3;
      first_pend = 1'b1;
      first_tgt = exp_fetch_pc;
    end
    if (hs_req) begin
      chk("fetch_addr", addr0, exp_fetch_pc);
      mq.push_back('{exp_fetch_pc, epoch, cyc_n + lat});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      if (gnt_budget > 0) gnt_budget--;
    end
    prev_pend = req0 & ~gnt;
    prev_addr = addr0;
  endtask

  task automatic adv();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin step(); adv(); end
  endtask

  task automatic drain();
    int n;
    gnt_budget = 0; ready_en = 1'b1; rsp_en = 1'b1;
    n = 0;
    while ((mq.size() != 0 || sb.size() != 0) && n < 60) begin step(); adv(); n++; end
    if (mq.size() != 0 || sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: pending mem=%0d inst=%0d expected 0", mq.size(), sb.size());
    end
    chk("drained_valid", 32'(valid0), 0);
  endtask

  initial begin
    int n;
    tv[0] = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tv[3] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tv[4] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tv[5] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};

    repeat (3) @(negedge clk);
    chk("reset_req", 32'(req0), 0);
    chk("reset_valid", 32'(valid0), 0);
    chk("reset_req1", 32'(req1), 0);
    chk("reset_addr1", addr1, RST1);
`ifdef RISCV_FETCH_PERF_EN
    chk("reset_perf_fetched", pf0, 0);
    chk("reset_perf_flushed", pl0, 0);
`endif
    rst = 1'b0;

    // Streaming from reset: one instruction per cycle, both reset PCs (incl. wrap).
    foreach (tv[i]) begin
      gnt_budget = tv[i].gnt ? -1 : 0;
      ready_en   = tv[i].rdy;
      step();
      chk("t1_req", 32'(req0), 32'(tv[i].exp_req));
      if (tv[i].exp_req) begin
        chk("t1_addr", addr0, tv[i].exp_addr);
        chk("t5_addr1", addr1, RST1 + tv[i].exp_addr);
      end
      chk("t1_valid", 32'(valid0), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) begin
        chk("t1_pc", pc0, tv[i].exp_pc);
        chk("t5_pc1", pc1, RST1 + tv[i].exp_pc);
      end
      adv();
    end
    run(10);
    drain();

    // Decoder stall: exactly DEPTH entries buffered, issue stops.
    gnt_budget = -1; ready_en = 1'b0;
    run(10);
    chk("t2_req_off", 32'(req0), 0);
    chk("t2_valid", 32'(valid0), 1);
    chk("t2_buffered", 32'(sb.size()), 4);
    ready_en = 1'b1;
    run(10);
    drain();

    // Redirect with two outstanding requests.
    rsp_en = 1'b0; gnt_budget = -1;
    run(3);
    chk("t3_req_capped", 32'(req0), 0);
    chk("t3_outstanding", 32'(mq.size()), 2);
    redir = 1'b1; redir_pc = 32'h0000_0103;
    step(); adv();
    redir = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin step(); chk("t3_flush_req", 32'(req0), 0); adv(); end
    step();
    chk("t3_resume_req", 32'(req0), 1);
    chk("t3_resume_addr", addr0, 32'h0000_0100);
    adv();
    run(8);
    drain();

    // Redirect coinciding with a response and an offered grant.
    lat = 2; gnt_budget = -1;
    run(6);
    n = 0;
    while (!(mq.size() > 0 && mq[0].due <= cyc_n) && n < 20) begin step(); adv(); n++; end
    redir = 1'b1; redir_pc = 32'h0000_0200;
    step();
    chk("t4_rsp_in_redirect", 32'(rvalid), 1);
    adv();
    redir = 1'b0; lat = 1;
    run(12);
    drain();

    // Back-to-back redirects: only the last target survives.
    gnt_budget = -1;
    run(4);
    redir = 1'b1;
    redir_pc = 32'h0000_0300; step(); adv();
    redir_pc = 32'h0000_0404; step(); adv();
    redir_pc = 32'h0000_050A; step(); adv();
    redir = 1'b0;
    chk("b2b_target", first_tgt, 32'h0000_0508);
    run(12);
    drain();

    // Reset mid-transaction, then perf scenario: 5 delivered, 3 flushed.
    gnt_budget = -1;
    run(3);
    rst = 1'b1; rvalid = 1'b0; gnt = 1'b0;
    #1;
    chk("midrst_req", 32'(req0), 0);
    chk("midrst_valid", 32'(valid0), 0);
    chk("midrst_addr", addr0, 32'h0);
    adv();
    rst = 1'b0;
    mq.delete(); sb.delete();
    exp_fetch_pc = 32'h0; prev_pend = 1'b0; first_pend = 1'b0; delivered = 0;
    gnt_budget = 5; ready_en = 1'b1;
    n = 0;
    while (delivered < 5 && n < 40) begin step(); adv(); n++; end
    chk("t6_delivered", 32'(delivered), 5);
    ready_en = 1'b0; gnt_budget = 3;
    run(8);
    chk("t6_buffered", 32'(sb.size()), 3);
    redir = 1'b1; redir_pc = 32'h0000_0040; gnt_budget = 0;
    step(); adv();
    redir = 1'b0;
    chk("t6_flushed_valid", 32'(valid0), 0);
`ifdef RISCV_FETCH_PERF_EN
    chk("perf_fetched", pf0, 5);
    chk("perf_flushed", pl0, 3);
    chk("perf_fetched1", pf1, 5);
    chk("perf_flushed1", pl1, 3);
`endif
    ready_en = 1'b1; gnt_budget = -1;
    run(6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

endmodule
